qubit_measure: RTL and testbench

- Measurement unit that reads one qubit's amplitudes (alpha, beta; 16-bit signed Q8.8 complex) and computes |alpha|^2 and |beta|^2 with a single shared multiplier.
- Draws a pseudo-random sample and decides outcome 0 or 1.
- Drives the collapsed basis state plus a one-cycle write strobe back to the qubit state register.
- Sits between the state register outputs and its new-state/update inputs; the controller issues meas_start.

---
 rtl/qubit_measure.sv | 195 +++++++++++++++++++
 tb/tb_qubit_measure.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/qubit_measure.sv
// Single-qubit measurement unit.
// Squares the latched amplitudes one at a time through a shared signed
// multiplier, scales the total probability by a pseudo-random sample and
// collapses the qubit to |0> or |1>. The collapsed state is written back to
// the state register with a one-cycle update strobe.
module qubit_measure #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] FP_ONE    = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        meas_start,
    input  logic [15:0] alpha_re,
    input  logic [15:0] alpha_im,
    input  logic [15:0] beta_re,
    input  logic [15:0] beta_im,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        rnd_force_en,
    input  logic [15:0] rnd_force,
    output logic        busy,
    output logic        meas_valid,
    output logic        meas_result,
    output logic        norm_err,
    output logic        update_en,
    output logic [15:0] new_alpha_re,
    output logic [15:0] new_alpha_im,
    output logic [15:0] new_beta_re,
    output logic [15:0] new_beta_im
);

    typedef enum logic [2:0] {
        IDLE,
        SQ0,
        SQ1,
        SQ2,
        SQ3,
        THR,
        DECIDE,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_t state;
    state_t next_state;

    // Amplitudes captured at start so the inputs may change mid-measurement.
    logic [15:0] a_re;
    logic [15:0] a_im;
    logic [15:0] b_re;
    logic [15:0] b_im;

    logic [31:0] p0;     // |alpha|^2
    logic [32:0] tot;    // |alpha|^2 + |beta|^2
    logic [15:0] rnd;    // random sample latched in SQ3
    logic [32:0] thr;    // (tot * rnd) >> 16
    logic [15:0] lfsr;

    logic        result_q;
    logic [15:0] new_alpha_re_q;
    logic [15:0] new_beta_re_q;

    // Shared squarer: operand chosen by the current square step.
    logic [15:0]        sq_op;
    logic signed [31:0] sq_op_ext;
    logic signed [31:0] sq;
    logic [31:0]        sq_u;
    logic               decide_one;

    // Select the amplitude component squared this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sq_op = a_re;
        unique case (state)
            SQ1:     sq_op = a_im;
            SQ2:     sq_op = b_re;
            SQ3:     sq_op = b_im;
            default: sq_op = a_re;
        endcase
    end

    assign sq_op_ext = {{16{sq_op[15]}}, sq_op};
    assign sq        = sq_op_ext * sq_op_ext;
    // A square is never negative, so reinterpreting as unsigned is exact.
    assign sq_u      = $unsigned(sq);

    // Outcome 1 only for a non-degenerate state whose threshold reaches p0.
    assign decide_one = (tot != 33'd0) && !(thr < {1'b0, p0});

    // Galois LFSR: free-running, seed_load overrides, zero seed is replaced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed sequence once a start is accepted in IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = meas_start ? SQ0 : IDLE;
            SQ0:     next_state = SQ1;
            SQ1:     next_state = SQ2;
            SQ2:     next_state = SQ3;
            SQ3:     next_state = THR;
            THR:     next_state = DECIDE;
            DECIDE:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch, accumulate, threshold and decide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_re           <= '0;
            a_im           <= '0;
            b_re           <= '0;
            b_im           <= '0;
            p0             <= '0;
            tot            <= '0;
            rnd            <= '0;
            thr            <= '0;
            result_q       <= 1'b0;
            new_alpha_re_q <= '0;
            new_beta_re_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (meas_start) begin
                        a_re <= alpha_re;
                        a_im <= alpha_im;
                        b_re <= beta_re;
                        b_im <= beta_im;
                        p0   <= '0;
                        tot  <= '0;
                    end
                end
                SQ0, SQ1: begin
                    p0  <= p0 + sq_u;
                    tot <= tot + {1'b0, sq_u};
                end
                SQ2: begin
                    tot <= tot + {1'b0, sq_u};
                end
                SQ3: begin
                    tot <= tot + {1'b0, sq_u};
                    rnd <= rnd_force_en ? rnd_force : lfsr;
                end
                THR: begin
                    // Operands widened to 49 bits so the full product survives.
                    thr <= 33'(({16'h0000, tot} * {33'h0, rnd}) >> 16);
                end
                DECIDE: begin
                    result_q       <= decide_one;
                    new_alpha_re_q <= decide_one ? 16'h0000 : FP_ONE;
                    new_beta_re_q  <= decide_one ? FP_ONE : 16'h0000;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: strobes are high exactly while in DONE (the cycle after DECIDE).
    always_comb begin
        busy         = (state != IDLE);
        meas_valid   = (state == DONE);
        update_en    = (state == DONE);
        norm_err     = (state == DONE) && (tot == 33'd0);
        meas_result  = result_q;
        new_alpha_re = new_alpha_re_q;
        new_alpha_im = 16'h0000;   // global phase is dropped on collapse
        new_beta_re  = new_beta_re_q;
        new_beta_im  = 16'h0000;
    end

endmodule

// File: tb/tb_qubit_measure.sv
// Directed self-checking bench for qubit_measure.
module tb_qubit_measure;

    logic        clk;
    logic        reset;
    logic        meas_start;
    logic [15:0] alpha_re;
    logic [15:0] alpha_im;
    logic [15:0] beta_re;
    logic [15:0] beta_im;
    logic        seed_load;
    logic [15:0] seed;
    logic        rnd_force_en;
    logic [15:0] rnd_force;
    logic        busy;
    logic        meas_valid;
    logic        meas_result;
    logic        norm_err;
    logic        update_en;
    logic [15:0] new_alpha_re;
    logic [15:0] new_alpha_im;
    logic [15:0] new_beta_re;
    logic [15:0] new_beta_im;

    int total = 0;
    int bad   = 0;
    int pulses;

    qubit_measure dut (
        .clk          (clk),
        .reset        (reset),
        .meas_start   (meas_start),
        .alpha_re     (alpha_re),
        .alpha_im     (alpha_im),
        .beta_re      (beta_re),
        .beta_im      (beta_im),
        .seed_load    (seed_load),
        .seed         (seed),
        .rnd_force_en (rnd_force_en),
        .rnd_force    (rnd_force),
        .busy         (busy),
        .meas_valid   (meas_valid),
        .meas_result  (meas_result),
        .norm_err     (norm_err),
        .update_en    (update_en),
        .new_alpha_re (new_alpha_re),
        .new_alpha_im (new_alpha_im),
        .new_beta_re  (new_beta_re),
        .new_beta_im  (new_beta_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic set_amp(input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] br, input logic [15:0] bi);
        alpha_re = ar;
        alpha_im = ai;
        beta_re  = br;
        beta_im  = bi;
    endtask

    // One measurement from IDLE; amplitudes are scrambled after the start edge
    // to show they were latched.
    task automatic run_meas(input string tag, input logic exp_res, input logic exp_norm,
                            input logic [15:0] exp_nar, input logic [15:0] exp_nbr);
        meas_start = 1'b1;
        @(posedge clk); #1;                        // E0
        chk({tag, " busy@E0"}, busy, 1);
        meas_start = 1'b0;
        set_amp(16'h7FFF, 16'h8001, 16'h1234, 16'hC000);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) chk({tag, " valid early"}, meas_valid, 0);
        end
        chk({tag, " valid"}, meas_valid, 1);       // after E6
        chk({tag, " update_en"}, update_en, 1);
        chk({tag, " result"}, meas_result, exp_res);
        chk({tag, " norm_err"}, norm_err, exp_norm);
        chk({tag, " new_alpha_re"}, new_alpha_re, exp_nar);
        chk({tag, " new_alpha_im"}, new_alpha_im, 0);
        chk({tag, " new_beta_re"}, new_beta_re, exp_nbr);
        chk({tag, " new_beta_im"}, new_beta_im, 0);
        @(posedge clk); #1;                        // E7
        chk({tag, " valid drop"}, meas_valid, 0);
        chk({tag, " update drop"}, update_en, 0);
        chk({tag, " norm drop"}, norm_err, 0);
        chk({tag, " busy drop"}, busy, 0);
        chk({tag, " result hold"}, meas_result, exp_res);
    endtask

    initial begin
        reset        = 1'b1;
        meas_start   = 1'b0;
        seed_load    = 1'b0;
        seed         = 16'h0000;
        rnd_force_en = 1'b0;
        rnd_force    = 16'h0000;
        set_amp(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst busy", busy, 0);
        chk("rst valid", meas_valid, 0);
        chk("rst update", update_en, 0);
        chk("rst result", meas_result, 0);
        chk("rst norm", norm_err, 0);
        chk("rst new_alpha_re", new_alpha_re, 0);
        chk("rst new_beta_re", new_beta_re, 0);
        chk("rst lfsr", dut.lfsr, 16'hACE1);
        reset = 1'b0;
        @(negedge clk);

        // 1: |0> with free-running LFSR always measures 0
        for (int i = 0; i < 20; i++) begin
            set_amp(16'h0100, 16'h0000, 16'h0000, 16'h0000);
            run_meas("t1 |0>", 1'b0, 1'b0, 16'h0100, 16'h0000);
        end

        // 2: |1> with forced zero sample measures 1
        rnd_force_en = 1'b1;
        rnd_force    = 16'h0000;
        set_amp(16'h0000, 16'h0000, 16'h0100, 16'h0000);
        run_meas("t2 |1>", 1'b1, 1'b0, 16'h0000, 16'h0100);

        // 3: equal superposition, threshold boundary
        rnd_force = 16'h7FFF;
        set_amp(16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
        run_meas("t3 r=7FFF", 1'b0, 1'b0, 16'h0100, 16'h0000);
        rnd_force = 16'h8000;
        set_amp(16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
        run_meas("t3 r=8000", 1'b1, 1'b0, 16'h0000, 16'h0100);

        // 4: -1.0 imaginary alpha, maximum sample, phase dropped
        rnd_force = 16'hFFFF;
        set_amp(16'h0000, 16'hFF00, 16'h0000, 16'h0000);
        run_meas("t4 -i", 1'b0, 1'b0, 16'h0100, 16'h0000);

        // 5: zero state flags norm_err
        rnd_force = 16'h1234;
        set_amp(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_meas("t5 zero", 1'b0, 1'b1, 16'h0100, 16'h0000);

        // 6a: meas_start held high through one operation
        rnd_force_en = 1'b0;
        set_amp(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        pulses = 0;
        meas_start = 1'b1;
        for (int k = 0; k < 8; k++) begin          // E0..E7
            @(posedge clk); #1;
            if (meas_valid) pulses++;
        end
        meas_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (meas_valid) pulses++;
        end
        chk("t6 hold pulses", pulses, 1);
        chk("t6 hold busy", busy, 0);

        // 6b: reset during SQ2 aborts
        meas_start = 1'b1;
        @(posedge clk); #1;                        // E0
        meas_start = 1'b0;
        @(posedge clk); #1;                        // E1
        @(posedge clk); #1;                        // E2 -> in SQ2
        reset = 1'b1;
        #1;
        chk("t6 abort busy", busy, 0);
        chk("t6 abort valid", meas_valid, 0);
        chk("t6 abort update", update_en, 0);
        chk("t6 abort new_alpha_re", new_alpha_re, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (meas_valid || update_en) pulses++;
        end
        chk("t6 abort pulses", pulses, 0);
        chk("t6 abort idle", busy, 0);

        // 6c: seed handling
        @(negedge clk);
        seed      = 16'h0000;
        seed_load = 1'b1;
        @(posedge clk); #1;
        chk("t6 seed0 load", dut.lfsr, 16'hACE1);
        seed_load = 1'b0;
        @(posedge clk); #1;
        chk("t6 seed0 next", dut.lfsr, 16'hE270);
        seed      = 16'h1234;
        seed_load = 1'b1;
        @(posedge clk); #1;
        chk("t6 seed load", dut.lfsr, 16'h1234);
        seed_load = 1'b0;
        @(posedge clk); #1;
        chk("t6 seed next", dut.lfsr, 16'h091A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
